vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 99 +++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_timing_gen                                                |
// | Purpose  : VGA raster counters, sync/blank flags and frame tick, all     |
// |            registered; optional colour bars via VGA_TIMING_TEST_PATTERN_EN|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+

`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif
`ifndef VGA_MERGE
`define VGA_MERGE(hs_, vs_, hb_, vb_, hc_, vc_, rgb_) {hs_, vs_, hb_, vb_, hc_, vc_, rgb_}
`endif

module vga_timing_gen #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29
) (
  input  logic                       pclk,
  input  logic                       rst,
  output logic [`VGA_BUS_SIZE-1:0]   vga_out,
  output logic                       frame_tick
);

  localparam logic [10:0] c_H_ACTIVE   = 11'(H_ACTIVE);
  localparam logic [10:0] c_H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] c_HS_FIRST   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] c_HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] c_V_ACTIVE   = 11'(V_ACTIVE);
  localparam logic [10:0] c_V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] c_VS_FIRST   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] c_VS_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] r_hcount, r_vcount;
  logic [10:0] w_hcount_nxt, w_vcount_nxt;
  logic        r_hs, r_vs, r_hblnk, r_vblnk, r_frame_tick;
  logic        w_hs_nxt, w_vs_nxt, w_hblnk_nxt, w_vblnk_nxt, w_tick_nxt;
  logic [11:0] r_rgb, w_rgb_nxt;

  always_comb begin
    w_hcount_nxt = r_hcount + 11'd1;
    w_vcount_nxt = r_vcount;
    if (r_hcount == c_H_LAST) begin
      w_hcount_nxt = 11'd0;
      w_vcount_nxt = (r_vcount == c_V_LAST) ? 11'd0 : r_vcount + 11'd1;
    end
  end

  // Flags decode the upcoming count so they land on the bus with it.
  assign w_hblnk_nxt = (w_hcount_nxt >= c_H_ACTIVE);
  assign w_vblnk_nxt = (w_vcount_nxt >= c_V_ACTIVE);
  assign w_hs_nxt    = !((w_hcount_nxt >= c_HS_FIRST) && (w_hcount_nxt <= c_HS_LAST));
  assign w_vs_nxt    = !((w_vcount_nxt >= c_VS_FIRST) && (w_vcount_nxt <= c_VS_LAST));
  assign w_tick_nxt  = (w_hcount_nxt == 11'd0) && (w_vcount_nxt == c_V_ACTIVE);

`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [2:0] w_bar;
  assign w_bar     = w_hcount_nxt[9:7];
  assign w_rgb_nxt = (w_hblnk_nxt || w_vblnk_nxt) ? 12'h000
                   : {{4{w_bar[2]}}, {4{w_bar[1]}}, {4{w_bar[0]}}};
`else
  assign w_rgb_nxt = 12'h000;
`endif

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_hcount     <= 11'd0;
      r_vcount     <= 11'd0;
      r_hblnk      <= 1'b0;
      r_vblnk      <= 1'b0;
      r_hs         <= 1'b1;
      r_vs         <= 1'b1;
      r_rgb        <= 12'h000;
      r_frame_tick <= 1'b0;
    end else begin
      r_hcount     <= w_hcount_nxt;
      r_vcount     <= w_vcount_nxt;
      r_hblnk      <= w_hblnk_nxt;
      r_vblnk      <= w_vblnk_nxt;
      r_hs         <= w_hs_nxt;
      r_vs         <= w_vs_nxt;
      r_rgb        <= w_rgb_nxt;
      r_frame_tick <= w_tick_nxt;
    end
  end

  assign vga_out    = `VGA_MERGE(r_hs, r_vs, r_hblnk, r_vblnk, r_hcount, r_vcount, r_rgb);
  assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire
